// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding instruction-memory read feeding a
// 2-entry prefetch buffer, with redirect flush and stale-response dropping.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_req;
    logic [31:0] r_req_addr;
    logic [31:0] r_fetch_pc;
    logic [1:0]  r_count;
    logic [31:0] r_buf_pc   [2];
    logic [31:0] r_buf_inst [2];

    logic        w_pop;
    logic        w_push;
    logic        w_wr_hi;
    logic        w_hold_addr;
    logic [1:0]  w_count_next;
    logic [31:0] w_redirect_target;
    logic [31:0] w_fetch_pc_next;
    logic        w_unused;

    assign w_unused          = &{1'b0, redirect_pc[1:0]};
    assign w_redirect_target = {redirect_pc[31:2], 2'b00};

    assign inst_valid = (r_count != 2'd0);
    assign inst       = inst_valid ? r_buf_inst[0] : 32'h0;
    assign inst_pc    = inst_valid ? r_buf_pc[0]   : 32'h0;
    assign imem_req   = r_req;
    assign imem_addr  = r_req_addr;

    always_comb begin
        w_pop  = inst_valid & inst_ready;
        w_push = (r_state == REQ) & imem_ack & ~redirect_valid;

        if (redirect_valid) begin
            w_count_next = 2'd0;
        end else begin
            w_count_next = r_count + {1'b0, w_push} - {1'b0, w_pop};
        end

        // Slot the incoming word lands in, after any same-cycle pop shifts the buffer.
        w_wr_hi = ((r_count - {1'b0, w_pop}) != 2'd0);

        if (redirect_valid) begin
            w_fetch_pc_next = w_redirect_target;
        end else if (w_push) begin
            w_fetch_pc_next = r_fetch_pc + 32'd4;
        end else begin
            w_fetch_pc_next = r_fetch_pc;
        end

        // A request abandoned by a redirect keeps its address on the bus until acked.
        w_hold_addr = ((r_state == REQ) & redirect_valid & ~imem_ack) |
                      ((r_state == DROP) & ~imem_ack);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_req      <= 1'b0;
            r_req_addr <= RESET_PC;
            r_fetch_pc <= RESET_PC;
            r_count    <= 2'd0;
        end else begin
            r_count    <= w_count_next;
            r_fetch_pc <= w_fetch_pc_next;
            if (!w_hold_addr) begin
                r_req_addr <= w_fetch_pc_next;
            end

            case (r_state)
                IDLE: begin
                    if (!redirect_valid && (w_count_next < 2'd2)) begin
                        r_state <= REQ;
                        r_req   <= 1'b1;
                    end
                end
                REQ: begin
                    if (redirect_valid) begin
                        if (imem_ack) begin
                            r_state <= IDLE;
                            r_req   <= 1'b0;
                        end else begin
                            r_state <= DROP;
                        end
                    end else if (imem_ack && (w_count_next >= 2'd2)) begin
                        r_state <= IDLE;
                        r_req   <= 1'b0;
                    end
                end
                DROP: begin
                    if (imem_ack) begin
                        r_state <= IDLE;
                        r_req   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    // Buffer payload carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (w_pop) begin
            r_buf_pc[0]   <= r_buf_pc[1];
            r_buf_inst[0] <= r_buf_inst[1];
        end
        if (w_push) begin
            r_buf_pc[w_wr_hi]   <= r_fetch_pc;
            r_buf_inst[w_wr_hi] <= imem_rdata;
        end
    end

    assert property (@(posedge clk) disable iff (rst) r_count <= 2'd2);

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus a randomized run scored against
// the expected sequential instruction stream.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    logic        imem_req_w;
    logic [31:0] imem_addr_w;
    logic        imem_ack_w;
    logic [31:0] imem_rdata_w;
    logic        redirect_valid_w;
    logic [31:0] redirect_pc_w;
    logic        inst_valid_w;
    logic [31:0] inst_w;
    logic [31:0] inst_pc_w;
    logic        inst_ready_w;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .inst_valid    (inst_valid),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .inst_ready    (inst_ready)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req_w),
        .imem_addr     (imem_addr_w),
        .imem_ack      (imem_ack_w),
        .imem_rdata    (imem_rdata_w),
        .redirect_valid(redirect_valid_w),
        .redirect_pc   (redirect_pc_w),
        .inst_valid    (inst_valid_w),
        .inst          (inst_w),
        .inst_pc       (inst_pc_w),
        .inst_ready    (inst_ready_w)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; the wrap instance always sees an always-acking memory.
    task automatic step();
        imem_ack_w   = imem_req_w;
        imem_rdata_w = imem_req_w ? mem_word(imem_addr_w) : 32'h0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_mem();
        imem_ack   = imem_req;
        imem_rdata = imem_req ? mem_word(imem_addr) : 32'h0;
    endtask

    task automatic idle_inputs();
        imem_ack       = 1'b0;
        imem_rdata     = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        step();
        check_eq("rst_req",     {31'h0, imem_req},   32'h0);
        check_eq("rst_valid",   {31'h0, inst_valid}, 32'h0);
        check_eq("rst_inst",    inst,                32'h0);
        check_eq("rst_inst_pc", inst_pc,             32'h0);
        step();
        rst = 1'b0;
        check_eq("first_req_pre", {31'h0, imem_req}, 32'h0);
    endtask

    initial begin
        logic [31:0] exp_pc;
        logic [31:0] prev_addr;
        logic        prev_hold;
        int          n_pops;

        rst              = 1'b1;
        idle_inputs();
        imem_ack_w       = 1'b0;
        imem_rdata_w     = 32'h0;
        redirect_valid_w = 1'b0;
        redirect_pc_w    = 32'h0;
        inst_ready_w     = 1'b1;

        // Streaming after reset, including the wrapping instance.
        do_reset();
        step();
        check_eq("first_req",      {31'h0, imem_req},   32'h1);
        check_eq("first_addr",     imem_addr,           32'h0);
        check_eq("first_valid",    {31'h0, inst_valid}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            inst_ready = 1'b1;
            drive_mem();
            step();
            check_eq("stream_valid", {31'h0, inst_valid}, 32'h1);
            check_eq("stream_pc",    inst_pc,             32'(4 * i));
            check_eq("stream_inst",  inst,                mem_word(32'(4 * i)));
            if (i < 3) begin
                check_eq("wrap_pc",   inst_pc_w, 32'hFFFF_FFF8 + 32'(4 * i));
                check_eq("wrap_inst", inst_w,    mem_word(32'hFFFF_FFF8 + 32'(4 * i)));
            end
        end

        // Asynchronous reset in the middle of a request, then a stray ack.
        @(negedge clk);
        imem_ack = 1'b0;
        rst = 1'b1;
        #1;
        check_eq("async_req",     {31'h0, imem_req},   32'h0);
        check_eq("async_valid",   {31'h0, inst_valid}, 32'h0);
        check_eq("async_inst",    inst,                32'h0);
        check_eq("async_inst_pc", inst_pc,             32'h0);
        @(negedge clk);
        rst        = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ack = 1'b0;
        check_eq("stray_valid", {31'h0, inst_valid}, 32'h0);
        check_eq("restart_req", {31'h0, imem_req},   32'h1);
        check_eq("restart_addr", imem_addr,          32'h0);

        // Backpressure fills the buffer, then fetching resumes without gaps.
        do_reset();
        step();
        for (int i = 0; i < 4; i++) begin
            drive_mem();
            step();
        end
        check_eq("full_req",   {31'h0, imem_req},   32'h0);
        check_eq("full_addr",  imem_addr,           32'h8);
        check_eq("full_valid", {31'h0, inst_valid}, 32'h1);
        check_eq("full_head",  inst_pc,             32'h0);
        exp_pc = 32'h0;
        for (int i = 0; i < 10; i++) begin
            inst_ready = 1'b1;
            if (inst_valid) begin
                check_eq("resume_pc",   inst_pc, exp_pc);
                check_eq("resume_inst", inst,    mem_word(exp_pc));
                exp_pc += 32'd4;
            end
            drive_mem();
            step();
        end
        check_eq("resume_count", exp_pc, 32'd40);

        // Redirect while a request is outstanding and its ack is late.
        do_reset();
        step();
        drive_mem();
        step();
        check_eq("pre_redir_addr", imem_addr, 32'h4);
        imem_ack       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        step();
        redirect_valid = 1'b0;
        check_eq("drop_req",   {31'h0, imem_req},   32'h1);
        check_eq("drop_addr",  imem_addr,           32'h4);
        check_eq("drop_flush", {31'h0, inst_valid}, 32'h0);
        for (int i = 0; i < 2; i++) begin
            step();
            check_eq("drop_hold", imem_addr, 32'h4);
        end
        imem_ack   = 1'b1;
        imem_rdata = mem_word(32'h4);
        step();
        imem_ack = 1'b0;
        check_eq("drop_done_req",   {31'h0, imem_req},   32'h0);
        check_eq("drop_done_valid", {31'h0, inst_valid}, 32'h0);
        step();
        check_eq("redir_req",  {31'h0, imem_req}, 32'h1);
        check_eq("redir_addr", imem_addr,         32'h100);
        drive_mem();
        step();
        check_eq("redir_valid", {31'h0, inst_valid}, 32'h1);
        check_eq("redir_pc",    inst_pc,             32'h100);
        check_eq("redir_inst",  inst,                mem_word(32'h100));

        // Redirect coinciding with ack and pop while the buffer is full.
        do_reset();
        step();
        for (int i = 0; i < 3; i++) begin
            drive_mem();
            step();
        end
        check_eq("full2_valid", {31'h0, inst_valid}, 32'h1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        imem_ack       = 1'b1;
        imem_rdata     = 32'hBAD0_BAD0;
        inst_ready     = 1'b1;
        step();
        idle_inputs();
        check_eq("coll_valid", {31'h0, inst_valid}, 32'h0);
        check_eq("coll_req",   {31'h0, imem_req},   32'h0);
        step();
        check_eq("coll_next_req",  {31'h0, imem_req}, 32'h1);
        check_eq("coll_next_addr", imem_addr,         32'h200);
        drive_mem();
        step();
        check_eq("coll_first_pc", inst_pc, 32'h200);

        // Redirect coinciding with ack and pop during a live request.
        do_reset();
        step();
        drive_mem();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        imem_ack       = 1'b1;
        imem_rdata     = mem_word(32'h4);
        inst_ready     = 1'b1;
        step();
        idle_inputs();
        check_eq("ackredir_valid", {31'h0, inst_valid}, 32'h0);
        check_eq("ackredir_req",   {31'h0, imem_req},   32'h0);
        step();
        check_eq("ackredir_addr", imem_addr, 32'h300);

        // Randomized traffic against the expected instruction stream.
        do_reset();
        step();
        exp_pc    = 32'h0;
        prev_hold = 1'b0;
        prev_addr = 32'h0;
        n_pops    = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (prev_hold) begin
                check_eq("hold_req",  {31'h0, imem_req}, 32'h1);
                check_eq("hold_addr", imem_addr,         prev_addr);
            end
            if (inst_valid) begin
                check_eq("rnd_inst", inst, mem_word(inst_pc));
            end else begin
                check_eq("rnd_empty_inst", inst,    32'h0);
                check_eq("rnd_empty_pc",   inst_pc, 32'h0);
            end
            inst_ready = ($urandom_range(0, 9) < 7);
            if (imem_req) begin
                imem_ack   = ($urandom_range(0, 9) < 6);
                imem_rdata = mem_word(imem_addr);
            end else begin
                imem_ack   = ($urandom_range(0, 9) == 0);
                imem_rdata = $urandom;
            end
            redirect_valid = ($urandom_range(0, 39) == 0);
            redirect_pc    = $urandom;
            if (redirect_valid) begin
                exp_pc = {redirect_pc[31:2], 2'b00};
            end else if (inst_valid && inst_ready) begin
                check_eq("rnd_stream_pc", inst_pc, exp_pc);
                exp_pc += 32'd4;
                n_pops++;
            end
            prev_hold = imem_req && !imem_ack;
            prev_addr = imem_addr;
            step();
        end
        idle_inputs();
        check_eq("rnd_progress", {31'h0, (n_pops > 300)}, 32'h1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, fetch address loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 imem_req  output  1  instruction-memory read request.
REQ-005 imem_addr  output  32  word-aligned fetch address, valid while imem_req=1.
REQ-006 imem_ack  input  1  memory response valid; sampled only while imem_req=1.
REQ-007 imem_rdata  input  32  instruction word, valid with imem_ack.
REQ-008 redirect_valid  input  1  branch/jump taken in core; one-cycle pulse.
REQ-009 redirect_pc  input  32  new fetch target, valid with redirect_valid.
REQ-010 inst_valid  output  1  buffered instruction available to decode.
REQ-011 inst  output  32  instruction word at buffer head.
REQ-012 inst_pc  output  32  PC of inst.
REQ-013 inst_ready  input  1  decode consumes head when inst_valid & inst_ready.

Function
REQ-014 Prefetch buffer SHALL be 2 entries deep, FIFO order, each entry {pc[31:0], inst[31:0]}; count 0..2.
REQ-015 inst_valid SHALL equal (count != 0); inst/inst_pc SHALL show head entry, 0 when empty.
REQ-016 FSM states SHALL be IDLE, REQ, DROP; imem_req=1 in REQ and DROP, 0 in IDLE.
REQ-017 imem_addr SHALL equal fetch_pc and SHALL stay stable while imem_req=1 and imem_ack=0.
REQ-018 At most one memory request SHALL be outstanding.
REQ-019 IDLE -> REQ when count_next < 2 and redirect_valid=0.
REQ-020 REQ with imem_ack=1, redirect_valid=0: push {fetch_pc, imem_rdata}; fetch_pc += 4; stay REQ if count_next < 2, else IDLE.
REQ-021 count_next SHALL account for push and pop in the same cycle; push+pop with count=2 SHALL be legal, leaving count=2.
REQ-022 Pop SHALL occur when inst_valid & inst_ready; pop with count=0 SHALL have no effect.
REQ-023 fetch_pc increment SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-024 Latency: imem_ack at edge N with empty buffer -> inst_valid=1 in cycle after edge N.
REQ-025 redirect_valid=1 SHALL flush buffer (count=0, same-cycle push/pop ignored) and load fetch_pc <= {redirect_pc[31:2], 2'b00}.
REQ-026 Redirect in REQ with imem_ack=0 -> DROP; with imem_ack=1 -> response discarded, next state IDLE.
REQ-027 DROP: hold old imem_addr until imem_ack; ack data discarded; -> IDLE; further redirects in DROP update fetch_pc only.
REQ-028 Redirect in IDLE -> IDLE with new fetch_pc; request begins next cycle per REQ-019.
REQ-029 Redirect SHALL take priority over ack, push and pop in the same cycle.
REQ-030 No instruction fetched before a redirect SHALL appear on inst after it.

Reset
REQ-031 rst=1 SHALL immediately force state=IDLE, count=0, fetch_pc=RESET_PC, imem_req=0, inst_valid=0, inst=0, inst_pc=0.
REQ-032 Reset mid-request SHALL abandon the outstanding request; a later stray imem_ack while imem_req=0 SHALL be ignored.
REQ-033 First imem_req=1 SHALL appear one cycle after the first rising edge with rst=0.

Verification
REQ-034 Reset release, memory acks every cycle, inst_ready=1 -> inst_pc sequence 0x0,0x4,0x8,0xC with one instruction per cycle.
REQ-035 inst_ready=0, acks every cycle -> count reaches 2, imem_req drops to 0, fetch_pc=0x8; raise inst_ready -> fetching resumes at 0x8, no loss or duplicate.
REQ-036 Redirect to 0x0000_0103 while request to 0x4 outstanding, ack delayed 3 cycles -> DROP, 0x4 data discarded, next imem_addr=0x100, first inst_pc=0x100.
REQ-037 Redirect coinciding with ack and pop at count=2 -> count=0, data discarded, next request to redirect target.
REQ-038 RESET_PC=32'hFFFF_FFF8, acks every cycle -> inst_pc 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-039 rst asserted asynchronously mid-cycle during REQ -> imem_req and inst_valid low before next clock edge; restart at RESET_PC.
